// File: rtl/fpadd_sched_pkg.sv
// Shared types and defaults for the floating-point adder issue scheduler.
package fpadd_sched_pkg;

    localparam int LATENCY_DEF = 7;
    localparam int MAX_OUT_DEF = 4;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    typedef struct packed {
        logic    v;
        req_id_t id;
    } token_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; a tie goes to the requester not granted last.
module rr_arb2
    import fpadd_sched_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    input  logic [1:0] elig,
    output logic [1:0] gnt
);

    req_id_t last_q;

    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
        gnt = 2'b00;
        if (elig == 2'b11) begin
            gnt = (last_q == REQ_B) ? 2'b01 : 2'b10;
        end else begin
            gnt = elig;
        end
    end

    // NOTE: flops use non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clear) begin
            last_q <= REQ_B;
        end else if (gnt[0]) begin
            last_q <= REQ_A;
        end else if (gnt[1]) begin
            last_q <= REQ_B;
        end
    end

endmodule

// File: rtl/fpadd_sched.sv
// Shares one pipelined FP adder between requesters A and B, routing each sum
// back to its issuer via a shadow token pipeline of the adder's depth.
module fpadd_sched
    import fpadd_sched_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF,
    parameter int MAX_OUT = MAX_OUT_DEF
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        req_a_valid,
    input  logic [31:0] req_a_opa,
    input  logic [31:0] req_a_opb,
    output logic        req_a_ready,
    input  logic        req_b_valid,
    input  logic [31:0] req_b_opa,
    input  logic [31:0] req_b_opb,
    output logic        req_b_ready,
    input  logic        flush,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_sum,
    output logic        rsp_a_valid,
    output logic [31:0] rsp_a_sum,
    output logic        rsp_b_valid,
    output logic [31:0] rsp_b_sum,
    output logic        busy
);

    localparam int            CW      = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

    logic [CW-1:0] cnt_a;
    logic [CW-1:0] cnt_b;
    logic [1:0]    elig;
    logic [1:0]    gnt;
    token_t        pipe [LATENCY];
    token_t        tail;
    logic          retire_a;
    logic          retire_b;

    assign elig[0] = req_a_valid && (cnt_a < CNT_MAX) && !flush && !clear;
    assign elig[1] = req_b_valid && (cnt_b < CNT_MAX) && !flush && !clear;

    rr_arb2 u_arb (
        .clk   (clk),
        .clear (clear),
        .elig  (elig),
        .gnt   (gnt)
    );

    assign req_a_ready = gnt[0];
    assign req_b_ready = gnt[1];

    always_comb begin
        add_a = 32'h0;
        add_b = 32'h0;
        if (gnt[0]) begin
            add_a = req_a_opa;
            add_b = req_a_opb;
        end else if (gnt[1]) begin
            add_a = req_b_opa;
            add_b = req_b_opb;
        end
    end

    // The tail token lines up with add_sum, so retire is purely registered.
    assign tail        = pipe[LATENCY-1];
    assign retire_a    = tail.v && (tail.id == REQ_A);
    assign retire_b    = tail.v && (tail.id == REQ_B);
    assign rsp_a_valid = retire_a;
    assign rsp_b_valid = retire_b;
    assign rsp_a_sum   = add_sum;
    assign rsp_b_sum   = add_sum;

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            busy = busy | pipe[i].v;
        end
    end

    always_ff @(posedge clk) begin
        if (clear || flush) begin
            // NOTE: only the valid bits are reset; an id is ignored whenever its v is 0.
            for (int i = 0; i < LATENCY; i++) begin
                pipe[i].v <= 1'b0;
            end
        end else begin
            pipe[0].v  <= |gnt;
            pipe[0].id <= gnt[1] ? REQ_B : REQ_A;
            for (int i = 1; i < LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Issue and retire in the same cycle cancel; the cap keeps cnt within range.
    always_ff @(posedge clk) begin
        if (clear || flush) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (gnt[0] && !retire_a) begin
                cnt_a <= cnt_a + CW'(1);
            end else if (!gnt[0] && retire_a) begin
                cnt_a <= cnt_a - CW'(1);
            end
            if (gnt[1] && !retire_b) begin
                cnt_b <= cnt_b + CW'(1);
            end else if (!gnt[1] && retire_b) begin
                cnt_b <= cnt_b - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fpadd_sched.sv
// Self-checking bench for fpadd_sched: behavioural FP adder, response scoreboard,
// per-cycle grant/count table and directed flush/clear sequences.
module tb_fpadd_sched;
    import fpadd_sched_pkg::*;

    localparam int LAT  = LATENCY_DEF;
    localparam int MAXO = MAX_OUT_DEF;

    logic        clk = 1'b0;
    logic        clear;
    logic        req_a_valid, req_b_valid;
    logic [31:0] req_a_opa, req_a_opb, req_b_opa, req_b_opb;
    logic        req_a_ready, req_b_ready;
    logic        flush;
    logic [31:0] add_a, add_b, add_sum;
    logic        rsp_a_valid, rsp_b_valid;
    logic [31:0] rsp_a_sum, rsp_b_sum;
    logic        busy;

    fpadd_sched #(.LATENCY(LAT), .MAX_OUT(MAXO)) dut (
        .clk         (clk),
        .clear       (clear),
        .req_a_valid (req_a_valid),
        .req_a_opa   (req_a_opa),
        .req_a_opb   (req_a_opb),
        .req_a_ready (req_a_ready),
        .req_b_valid (req_b_valid),
        .req_b_opa   (req_b_opa),
        .req_b_opb   (req_b_opb),
        .req_b_ready (req_b_ready),
        .flush       (flush),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_sum     (add_sum),
        .rsp_a_valid (rsp_a_valid),
        .rsp_a_sum   (rsp_a_sum),
        .rsp_b_valid (rsp_b_valid),
        .rsp_b_sum   (rsp_b_sum),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Single-precision add via double arithmetic; exact for the operands used here.
    function automatic real sp_to_real(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'h0) d = {f[31], 63'h0};
        else                  d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'h0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real_to_sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        return real_to_sp(sp_to_real(a) + sp_to_real(b));
    endfunction

    logic [31:0] da [LAT];
    logic [31:0] db [LAT];
    always @(posedge clk) begin
        da[0] <= add_a;
        db[0] <= add_b;
        for (int i = 1; i < LAT; i++) begin
            da[i] <= da[i-1];
            db[i] <= db[i-1];
        end
    end
    assign add_sum = fp_add(da[LAT-1], db[LAT-1]);

    int checks   = 0;
    int failures = 0;
    int tick     = 0;
    int t0       = 0;
    bit mon_en   = 1'b0;

    always @(posedge clk) tick <= tick + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, tick - t0);
        end
    endtask

    typedef struct {
        req_id_t     id;
        logic [31:0] sum;
        int          due;
    } exp_t;
    exp_t sb[$];

    // Scoreboard: push on accepted issue, pop when its LATENCY-cycle slot comes up.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == tick) begin
                e = sb.pop_front();
                check("rsp_valid", {30'h0, rsp_b_valid, rsp_a_valid}, (e.id == REQ_A) ? 32'd1 : 32'd2);
                check("rsp_sum", (e.id == REQ_A) ? rsp_a_sum : rsp_b_sum, e.sum);
            end else if (rsp_a_valid || rsp_b_valid) begin
                check("rsp_unexpected", {30'h0, rsp_b_valid, rsp_a_valid}, 32'd0);
            end
            if (req_a_valid && req_a_ready) sb.push_back('{REQ_A, fp_add(req_a_opa, req_a_opb), tick + LAT});
            if (req_b_valid && req_b_ready) sb.push_back('{REQ_B, fp_add(req_b_opa, req_b_opb), tick + LAT});
            if (flush || clear) sb.delete();
        end
    end

    logic [31:0] fps [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                             32'h3F000000, 32'hBF800000, 32'h40A00000};

    typedef struct {
        bit seg_start;
        bit va;
        bit vb;
        bit exp_ra;
        bit exp_rb;
        int exp_cnt_a;
    } vec_t;

    task automatic idle_inputs();
        req_a_valid = 1'b0; req_b_valid = 1'b0; flush = 1'b0;
        req_a_opa = 32'h0; req_a_opb = 32'h0; req_b_opa = 32'h0; req_b_opb = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        clear = 1'b0;
        t0 = tick;
    endtask

    task automatic drive_a(input logic [31:0] a, input logic [31:0] b);
        req_a_valid = 1'b1; req_a_opa = a; req_a_opb = b;
    endtask

    task automatic drive_b(input logic [31:0] a, input logic [31:0] b);
        req_b_valid = 1'b1; req_b_opa = a; req_b_opb = b;
    endtask

    vec_t tbl [33];
    int   cont_cnt  [16] = '{0,1,1,2,2,3,3,4,3,3,2,2,1,1,0,0};
    int   limit_cnt [17] = '{0,1,2,3,4,4,4,4,3,3,3,3,4,4,4,4,3};
    bit   limit_rdy [17] = '{1,1,1,1,0,0,0,0,1,1,1,1,0,0,0,0,1};

    initial begin
        for (int t = 0; t < 16; t++) begin
            tbl[t] = '{(t == 0), (t < 8), (t < 8), (t < 8 && t % 2 == 0), (t < 8 && t % 2 == 1), cont_cnt[t]};
        end
        for (int t = 0; t < 17; t++) begin
            tbl[16 + t] = '{(t == 0), 1'b1, 1'b0, limit_rdy[t], 1'b0, limit_cnt[t]};
        end

        clear = 1'b1;
        idle_inputs();
        next_cycle();
        drive_a(fps[0], fps[1]);
        drive_b(fps[2], fps[3]);
        next_cycle();
        mon_en = 1'b1;
        sample();
        check("reset_ready_a", {31'h0, req_a_ready}, 32'd0);
        check("reset_ready_b", {31'h0, req_b_ready}, 32'd0);
        check("reset_add_a", add_a, 32'h0);
        check("reset_add_b", add_b, 32'h0);
        check("reset_rsp", {30'h0, rsp_b_valid, rsp_a_valid}, 32'd0);
        check("reset_busy", {31'h0, busy}, 32'd0);
        check("reset_cnt_a", 32'(dut.cnt_a), 32'd0);

        // Single op: 1.0 + 2.0 from A.
        do_reset();
        drive_a(32'h3F800000, 32'h40000000);
        sample();
        check("single_add_a", add_a, 32'h3F800000);
        check("single_add_b", add_b, 32'h40000000);
        check("single_ready", {30'h0, req_b_ready, req_a_ready}, 32'd1);
        next_cycle();
        idle_inputs();
        for (int t = 1; t < 10; t++) begin
            sample();
            check("single_rsp_a_valid", {31'h0, rsp_a_valid}, {31'h0, (t == 7)});
            check("single_rsp_b_valid", {31'h0, rsp_b_valid}, 32'd0);
            check("single_busy", {31'h0, busy}, {31'h0, (t <= 7)});
            if (t == 7) check("single_rsp_sum", rsp_a_sum, 32'h40400000);
            next_cycle();
        end

        // Contention and per-requester limit tables.
        for (int i = 0; i < 33; i++) begin
            if (tbl[i].seg_start) do_reset();
            idle_inputs();
            if (tbl[i].va) drive_a(fps[i % 6], fps[(i + 1) % 6]);
            if (tbl[i].vb) drive_b(fps[(i + 2) % 6], fps[(i + 3) % 6]);
            sample();
            check($sformatf("tbl%0d_ready_a", i), {31'h0, req_a_ready}, {31'h0, tbl[i].exp_ra});
            check($sformatf("tbl%0d_ready_b", i), {31'h0, req_b_ready}, {31'h0, tbl[i].exp_rb});
            check($sformatf("tbl%0d_cnt_a", i), 32'(dut.cnt_a), 32'(tbl[i].exp_cnt_a));
            next_cycle();
        end

        // Flush: discard three in-flight ops, keep the pointer.
        do_reset();
        drive_a(fps[0], fps[1]);
        sample(); check("flush_ready_a0", {31'h0, req_a_ready}, 32'd1); next_cycle();
        drive_a(fps[2], fps[0]);
        sample(); check("flush_ready_a1", {31'h0, req_a_ready}, 32'd1); next_cycle();
        idle_inputs(); drive_b(fps[1], fps[5]);
        sample(); check("flush_ready_b2", {31'h0, req_b_ready}, 32'd1); next_cycle();
        idle_inputs();
        sample();
        check("flush_cnt_a3", 32'(dut.cnt_a), 32'd2);
        check("flush_cnt_b3", 32'(dut.cnt_b), 32'd1);
        next_cycle();
        flush = 1'b1; drive_a(fps[0], fps[0]);
        sample();
        check("flush_no_grant", {31'h0, req_a_ready}, 32'd0);
        check("flush_busy4", {31'h0, busy}, 32'd1);
        next_cycle();
        flush = 1'b0; drive_a(32'h3F000000, 32'h3F000000);
        sample();
        check("flush_busy5", {31'h0, busy}, 32'd0);
        check("flush_cnt_a5", 32'(dut.cnt_a), 32'd0);
        check("flush_cnt_b5", 32'(dut.cnt_b), 32'd0);
        check("flush_ready_a5", {31'h0, req_a_ready}, 32'd1);
        next_cycle();
        idle_inputs();
        for (int t = 6; t < 14; t++) begin
            sample();
            check("flush_rsp_a", {31'h0, rsp_a_valid}, {31'h0, (t == 12)});
            check("flush_rsp_b", {31'h0, rsp_b_valid}, 32'd0);
            if (t == 12) check("flush_rsp_sum", rsp_a_sum, 32'h3F800000);
            next_cycle();
        end
        flush = 1'b1;
        next_cycle();
        flush = 1'b0; drive_a(fps[0], fps[1]); drive_b(fps[2], fps[3]);
        sample();
        check("flush_keeps_ptr", {30'h0, req_b_ready, req_a_ready}, 32'd2);
        next_cycle();
        idle_inputs();

        // Clear mid-flight: drops ops and resets the pointer back to B.
        do_reset();
        drive_b(fps[0], fps[2]);
        sample(); check("clr_ready_b0", {31'h0, req_b_ready}, 32'd1); next_cycle();
        idle_inputs(); drive_a(fps[1], fps[3]);
        sample(); check("clr_ready_a1", {31'h0, req_a_ready}, 32'd1); next_cycle();
        idle_inputs(); next_cycle();
        clear = 1'b1; drive_a(fps[0], fps[0]); drive_b(fps[1], fps[1]);
        sample(); check("clr_no_grant", {30'h0, req_b_ready, req_a_ready}, 32'd0); next_cycle();
        clear = 1'b0; idle_inputs();
        sample();
        check("clr_busy", {31'h0, busy}, 32'd0);
        check("clr_cnt_a", 32'(dut.cnt_a), 32'd0);
        check("clr_cnt_b", 32'(dut.cnt_b), 32'd0);
        check("clr_add_a", add_a, 32'h0);
        check("clr_rsp4", {30'h0, rsp_b_valid, rsp_a_valid}, 32'd0);
        next_cycle();
        for (int t = 5; t < 10; t++) begin
            sample();
            check("clr_rsp", {30'h0, rsp_b_valid, rsp_a_valid}, 32'd0);
            next_cycle();
        end
        drive_a(fps[0], fps[1]); drive_b(fps[2], fps[3]);
        sample(); check("clr_tie_to_a", {30'h0, req_b_ready, req_a_ready}, 32'd1); next_cycle();
        idle_inputs();

        for (int t = 0; t < LAT + 2; t++) next_cycle();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
